// File: rtl/vlsu_dual_issue_queue.sv
// Dual-channel VLSU request queue: separate load and store FIFOs, a
// type-order FIFO for strict program ordering, and per-unit in-flight
// counters. Dispatch channels use valid/ready: a transfer happens on a
// rising clk_i edge where valid and ready are both high; once raised,
// valid and its bits hold until that transfer (flush_i excepted).
module vlsu_dual_issue_queue #(
  parameter int DEPTH        = 4,
  parameter int REQ_W        = 64,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = $clog2(2*DEPTH+1),
  parameter int INF_W        = $clog2(MAX_INFLIGHT+1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             strict_i,
  input  logic             flush_i,
  input  logic             enq_valid_i,
  output logic             enq_ready_o,
  input  logic             enq_is_load_i,
  input  logic [REQ_W-1:0] enq_bits_i,
  output logic             ld_valid_o,
  input  logic             ld_ready_i,
  output logic [REQ_W-1:0] ld_bits_o,
  output logic             st_valid_o,
  input  logic             st_ready_i,
  output logic [REQ_W-1:0] st_bits_o,
  input  logic             ld_done_i,
  input  logic             st_done_i,
  output logic [CNT_W-1:0] count_o,
  output logic [INF_W-1:0] ld_inflight_o,
  output logic [INF_W-1:0] st_inflight_o,
  output logic             idle_o,
  output logic             err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [OW:0]      ORD_ONE = 1;
  localparam logic [INF_W-1:0] INF_ONE = 1;
  localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);

  logic [REQ_W-1:0] ld_mem [DEPTH];
  logic [REQ_W-1:0] st_mem [DEPTH];
  logic [2*DEPTH-1:0] ord_mem;

  logic [AW:0] ld_wptr, ld_rptr, st_wptr, st_rptr;
  logic [OW:0] ord_wptr, ord_rptr;
  logic [AW:0] ld_cnt, st_cnt;
  logic        ld_empty, ld_full, st_empty, st_full, ord_empty, ord_head;
  logic        mode_q, mode_eff;
  logic        ld_room, st_room;
  logic        enq_fire, ld_fire, st_fire;

  assign ld_empty  = (ld_wptr == ld_rptr);
  assign st_empty  = (st_wptr == st_rptr);
  assign ord_empty = (ord_wptr == ord_rptr);
  assign ld_full   = (ld_wptr[AW] != ld_rptr[AW]) && (ld_wptr[AW-1:0] == ld_rptr[AW-1:0]);
  assign st_full   = (st_wptr[AW] != st_rptr[AW]) && (st_wptr[AW-1:0] == st_rptr[AW-1:0]);
  assign ld_cnt    = ld_wptr - ld_rptr;
  assign st_cnt    = st_wptr - st_rptr;
  assign ord_head  = ord_mem[ord_rptr[OW-1:0]];

  assign count_o = CNT_W'(ld_cnt) + CNT_W'(st_cnt);
  assign idle_o  = (count_o == '0) && (ld_inflight_o == '0) && (st_inflight_o == '0);

  // While idle the incoming strict_i is what the latch will hold next cycle,
  // so an enqueue in that same cycle already follows the new mode. Nothing
  // can dispatch while idle, so only the order-FIFO push sees the difference.
  assign mode_eff = idle_o ? strict_i : mode_q;

  assign ld_room = (ld_inflight_o < INF_MAX);
  assign st_room = (st_inflight_o < INF_MAX);

  assign enq_ready_o = !rst_i && !flush_i && (enq_is_load_i ? !ld_full : !st_full);
  assign enq_fire    = enq_valid_i && enq_ready_o;
  assign ld_fire     = ld_valid_o && ld_ready_i;
  assign st_fire     = st_valid_o && st_ready_i;

  assign ld_bits_o = ld_mem[ld_rptr[AW-1:0]];
  assign st_bits_o = st_mem[st_rptr[AW-1:0]];

  // Dispatch valids: strict mode lets only the order-FIFO head type go and
  // only after the other unit has drained; relaxed mode runs both streams.
  always_comb begin
    ld_valid_o = 1'b0;
    st_valid_o = 1'b0;
    if (!rst_i && !flush_i) begin
      if (mode_eff) begin
        if (!ord_empty) begin
          if (ord_head) ld_valid_o = (st_inflight_o == '0) && ld_room;
          else          st_valid_o = (ld_inflight_o == '0) && st_room;
        end
      end else begin
        ld_valid_o = !ld_empty && ld_room;
        st_valid_o = !st_empty && st_room;
      end
    end
  end

  // Payload and order storage; written only on an accepted enqueue.
  always_ff @(posedge clk_i) begin
    if (enq_fire && enq_is_load_i)  ld_mem[ld_wptr[AW-1:0]] <= enq_bits_i;
    if (enq_fire && !enq_is_load_i) st_mem[st_wptr[AW-1:0]] <= enq_bits_i;
    if (enq_fire && mode_eff)       ord_mem[ord_wptr[OW-1:0]] <= enq_is_load_i;
  end

  // FIFO pointers; flush empties every FIFO in one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      ld_wptr  <= '0;
      ld_rptr  <= '0;
      st_wptr  <= '0;
      st_rptr  <= '0;
      ord_wptr <= '0;
      ord_rptr <= '0;
    end else begin
      if (enq_fire && enq_is_load_i)  ld_wptr <= ld_wptr + PTR_ONE;
      if (enq_fire && !enq_is_load_i) st_wptr <= st_wptr + PTR_ONE;
      if (ld_fire)                    ld_rptr <= ld_rptr + PTR_ONE;
      if (st_fire)                    st_rptr <= st_rptr + PTR_ONE;
      if (enq_fire && mode_eff)       ord_wptr <= ord_wptr + ORD_ONE;
      if (mode_eff && (ld_fire || st_fire)) ord_rptr <= ord_rptr + ORD_ONE;
    end
  end

  // In-flight counters and the sticky underflow error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_inflight_o <= '0;
      st_inflight_o <= '0;
      err_o         <= 1'b0;
    end else begin
      case ({ld_fire, ld_done_i})
        2'b10:   ld_inflight_o <= ld_inflight_o + INF_ONE;
        2'b01:   if (ld_inflight_o == '0) err_o <= 1'b1;
                 else ld_inflight_o <= ld_inflight_o - INF_ONE;
        default: ;
      endcase
      case ({st_fire, st_done_i})
        2'b10:   st_inflight_o <= st_inflight_o + INF_ONE;
        2'b01:   if (st_inflight_o == '0) err_o <= 1'b1;
                 else st_inflight_o <= st_inflight_o - INF_ONE;
        default: ;
      endcase
    end
  end

  // Ordering-mode latch: follows strict_i only while fully idle.
  always_ff @(posedge clk_i) begin
    if (rst_i)       mode_q <= 1'b1;
    else if (idle_o) mode_q <= strict_i;
  end

endmodule

// File: tb/tb_vlsu_dual_issue_queue.sv
// Bench for vlsu_dual_issue_queue: directed scenarios plus random traffic,
// checked every cycle against a program-order queue model.
module tb_vlsu_dual_issue_queue;
  localparam int DEPTH = 4;
  localparam int REQ_W = 64;
  localparam int MAXI  = 4;
  localparam int CNT_W = $clog2(2*DEPTH+1);
  localparam int INF_W = $clog2(MAXI+1);

  logic clk, rst, strict, flush, enq_valid, enq_ready, enq_is_load;
  logic [REQ_W-1:0] enq_bits, ld_bits, st_bits;
  logic ld_valid, ld_ready, st_valid, st_ready, ld_done, st_done, idle, err;
  logic [CNT_W-1:0] count;
  logic [INF_W-1:0] ld_inf, st_inf;

  vlsu_dual_issue_queue #(.DEPTH(DEPTH), .REQ_W(REQ_W), .MAX_INFLIGHT(MAXI)) dut (
    .clk_i(clk), .rst_i(rst), .strict_i(strict), .flush_i(flush),
    .enq_valid_i(enq_valid), .enq_ready_o(enq_ready), .enq_is_load_i(enq_is_load),
    .enq_bits_i(enq_bits), .ld_valid_o(ld_valid), .ld_ready_i(ld_ready),
    .ld_bits_o(ld_bits), .st_valid_o(st_valid), .st_ready_i(st_ready),
    .st_bits_o(st_bits), .ld_done_i(ld_done), .st_done_i(st_done),
    .count_o(count), .ld_inflight_o(ld_inf), .st_inflight_o(st_inf),
    .idle_o(idle), .err_o(err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every buffered request in program order, plus counters.
  typedef struct { logic is_load; logic [REQ_W-1:0] bits; } ent_t;
  ent_t m_q[$];
  int   m_ldi, m_sti, t_ld, t_st;
  logic m_err, m_mode, m_idle;
  int   nl, ns, fl, fs;
  logic e_ldv, e_stv, e_rdy, f_ld, f_st;

  // Compare process: outputs vs model on the falling edge, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("enq_ready_in_reset", enq_ready, 0);
      m_q.delete(); m_ldi = 0; m_sti = 0; m_err = 0; m_mode = 1;
    end else begin
      nl = 0; ns = 0; fl = -1; fs = -1;
      foreach (m_q[i]) begin
        if (m_q[i].is_load) begin if (fl < 0) fl = i; nl++; end
        else begin if (fs < 0) fs = i; ns++; end
      end
      m_idle = (m_q.size() == 0) && (m_ldi == 0) && (m_sti == 0);
      e_ldv = 0; e_stv = 0;
      if (!flush) begin
        if (m_mode) begin
          if (m_q.size() > 0) begin
            if (m_q[0].is_load) e_ldv = (m_sti == 0) && (m_ldi < MAXI);
            else                e_stv = (m_ldi == 0) && (m_sti < MAXI);
          end
        end else begin
          e_ldv = (fl >= 0) && (m_ldi < MAXI);
          e_stv = (fs >= 0) && (m_sti < MAXI);
        end
      end
      e_rdy = !flush && (enq_is_load ? (nl < DEPTH) : (ns < DEPTH));
      chk("enq_ready", enq_ready, e_rdy);
      chk("ld_valid", ld_valid, e_ldv);
      chk("st_valid", st_valid, e_stv);
      if (e_ldv) chk("ld_bits", ld_bits, m_q[fl].bits);
      if (e_stv) chk("st_bits", st_bits, m_q[fs].bits);
      chk("count", count, m_q.size());
      chk("ld_inflight", ld_inf, m_ldi);
      chk("st_inflight", st_inf, m_sti);
      chk("idle", idle, m_idle);
      chk("err", err, m_err);
      f_ld = e_ldv && ld_ready;
      f_st = e_stv && st_ready;
      if (flush) m_q.delete();
      else begin
        if (f_ld && f_st) begin
          if (fl > fs) begin m_q.delete(fl); m_q.delete(fs); end
          else         begin m_q.delete(fs); m_q.delete(fl); end
        end else if (f_ld) m_q.delete(fl);
        else if (f_st) m_q.delete(fs);
        if (enq_valid && e_rdy) m_q.push_back('{enq_is_load, enq_bits});
      end
      t_ld = m_ldi + int'(f_ld) - int'(ld_done);
      t_st = m_sti + int'(f_st) - int'(st_done);
      if (t_ld < 0) begin t_ld = 0; m_err = 1; end
      if (t_st < 0) begin t_st = 0; m_err = 1; end
      m_ldi = t_ld; m_sti = t_st;
      if (m_idle) m_mode = strict;
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic enq(input logic is_load, input logic [REQ_W-1:0] b);
    int t = 0;
    enq_valid = 1; enq_is_load = is_load; enq_bits = b;
    #1;
    while (!enq_ready && t < 200) begin @(posedge clk); #2; t++; end
    chk("enq_timeout", enq_ready, 1);
    @(posedge clk); #1;
    enq_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    enq_valid = 0; flush = 0; ld_ready = 1; st_ready = 1;
    while (!(m_q.size() == 0 && m_ldi == 0 && m_sti == 0) && t < 500) begin
      ld_done = (m_ldi > 0); st_done = (m_sti > 0);
      step(1); t++;
    end
    ld_done = 0; st_done = 0;
    chk("drain_timeout", (m_q.size() == 0 && m_ldi == 0 && m_sti == 0), 1);
    step(1);
  endtask

  task automatic set_mode(input logic s);
    strict = s;
    step(2);
  endtask

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      enq_valid   = ($urandom_range(0, 1) == 1);
      enq_is_load = ($urandom_range(0, 1) == 1);
      enq_bits    = {$urandom, $urandom};
      ld_ready    = ($urandom_range(0, 3) != 0);
      st_ready    = ($urandom_range(0, 3) != 0);
      ld_done     = (m_ldi > 0) && ($urandom_range(0, 2) == 0);
      st_done     = (m_sti > 0) && ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 49) == 0);
      step(1);
    end
    ld_done = 0; st_done = 0; flush = 0; enq_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; strict = 1; flush = 0; enq_valid = 0; enq_is_load = 1; enq_bits = '0;
    ld_ready = 1; st_ready = 1; ld_done = 0; st_done = 0;
    step(3);
    rst = 0;
    #1;
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_idle", idle, 1);

    // Strict: L0, L1 stream, S0 waits for loads to drain.
    enq(1, 64'h10); enq(1, 64'h11); enq(0, 64'h20);
    #1;
    chk("t1_ld_inflight", ld_inf, 2);
    step(2); #1;
    chk("t1_s0_held", st_valid, 0);
    chk("t1_count", count, 1);
    ld_done = 1; step(2); ld_done = 0; #1;
    chk("t1_s0_valid", st_valid, 1);
    chk("t1_s0_bits", st_bits, 64'h20);
    step(1); #1;
    chk("t1_st_inflight", st_inf, 1);
    drain();

    // Relaxed: pairs fire together.
    set_mode(0);
    ld_ready = 0; st_ready = 0;
    enq(1, 64'hA0); enq(0, 64'hB0); enq(1, 64'hA1); enq(0, 64'hB1);
    ld_ready = 1; st_ready = 1;
    step(2); #1;
    chk("t2_ld_inflight", ld_inf, 2);
    chk("t2_st_inflight", st_inf, 2);
    drain();

    // Full load FIFO; stores still accepted; no ready look-ahead.
    ld_ready = 0;
    for (int i = 0; i < 4; i++) enq(1, 64'hC0 + 64'(i));
    enq_valid = 1; enq_is_load = 1; enq_bits = 64'hC4; #1;
    chk("t3_full_ready", enq_ready, 0);
    chk("t3_full_count", count, 4);
    enq_is_load = 0; enq_bits = 64'hD0; #1;
    chk("t3_store_ready", enq_ready, 1);
    step(1);
    enq_is_load = 1; enq_bits = 64'hC4; ld_ready = 1; #1;
    chk("t3_no_lookahead", enq_ready, 0);
    step(1); ld_ready = 0; #1;
    chk("t3_fifth_ready", enq_ready, 1);
    step(1); enq_valid = 0;
    drain();

    // In-flight limit in strict mode.
    set_mode(1);
    ld_ready = 1;
    for (int i = 0; i < 6; i++) enq(1, 64'hE0 + 64'(i));
    step(3); #1;
    chk("t4_ld_valid_low", ld_valid, 0);
    chk("t4_ld_inflight", ld_inf, 4);
    chk("t4_count", count, 2);
    ld_done = 1; step(1); ld_done = 0; #1;
    chk("t4_reenable", ld_valid, 1);
    chk("t4_bits", ld_bits, 64'hE4);
    step(1); #1;
    chk("t4_inflight_4", ld_inf, 4);
    chk("t4_count_1", count, 1);
    drain();

    // Done pulse with nothing in flight.
    st_done = 1; step(1); st_done = 0; #1;
    chk("t5_err", err, 1);
    chk("t5_st_inflight", st_inf, 0);
    step(3); #1;
    chk("t5_err_sticky", err, 1);
    rst = 1; step(2); rst = 0; #1;
    chk("t5_err_cleared", err, 0);

    // Flush with requests buffered and loads in flight.
    enq(1, 64'hF0); enq(1, 64'hF1);
    enq(0, 64'hF2); enq(1, 64'hF3); enq(0, 64'hF4);
    step(1); #1;
    chk("t6_count", count, 3);
    chk("t6_ld_inflight", ld_inf, 2);
    flush = 1; #1;
    chk("t6_flush_ld_valid", ld_valid, 0);
    chk("t6_flush_ready", enq_ready, 0);
    step(1); flush = 0; #1;
    chk("t6_count_zero", count, 0);
    chk("t6_no_st_valid", st_valid, 0);
    chk("t6_inflight_kept", ld_inf, 2);
    ld_done = 1; step(2); ld_done = 0; #1;
    chk("t6_idle", idle, 1);

    // Random traffic in each mode.
    set_mode(1);
    random_phase(800);
    drain();
    set_mode(0);
    random_phase(800);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
